// File: rtl/caracter_pkg.sv
// caracter_pkg: shared constants for the "HOLA" text overlay.
//   X0_DEF / Y0_DEF   default top-left corner of the text box
//   GLYPH_W/GLYPH_H   glyph cell size in pixels
//   N_CHARS           number of glyphs in the box
//   FONT              64 x 8 font ROM contents, address {char, row}
//                     and bit 7 is the leftmost pixel of a row
package caracter_pkg;

    localparam int X0_DEF  = 288;
    localparam int Y0_DEF  = 232;
    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 16;
    localparam int N_CHARS = 4;

    localparam logic [7:0] FONT [0:N_CHARS*GLYPH_H-1] = '{
        // H
        8'h00, 8'h00, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hFE,
        8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00,
        // O
        8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6,
        8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00,
        // L
        8'h00, 8'h00, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0,
        8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFE, 8'h00, 8'h00,
        // A
        8'h00, 8'h00, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hC6, 8'hC6,
        8'hFE, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00
    };

endpackage

// File: rtl/caracter_font_rom.sv
// caracter_font_rom: combinational font lookup.
//   addr  in  6  {char[1:0], glyph_row[3:0]}
//   data  out 8  font row word, bit 7 = leftmost pixel
module caracter_font_rom
    import caracter_pkg::*;
(
    input  logic [5:0] addr,
    output logic [7:0] data
);

    assign data = FONT[addr];

endmodule

// File: rtl/caracter.sv
// caracter: fixed "HOLA" text overlay for the VGA pixel pipeline.
// Decodes the pixel coordinate into a glyph/row/column, looks up the
// font bit and registers the resulting colour for the DAC.
//   clk       pixel clock
//   rst       synchronous active-low reset (clears r/g/b only)
//   video_on  visible-area flag
//   pixel_x   current column, pixel_y current row
//   R, G, B   foreground colour
//   r, g, b   registered colour outputs (one cycle latency)
//   char, rowad, palabra, posicion, palabit  combinational debug lookups
// Build option: define CARACTER_BG_EN to paint the non-glyph pixels of
// the box in the inverse of the foreground colour.
module caracter
    import caracter_pkg::*;
#(
    parameter int X0 = X0_DEF,
    parameter int Y0 = Y0_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       video_on,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       R,
    input  logic       G,
    input  logic       B,
    output logic       r,
    output logic       g,
    output logic       b,
    output logic [1:0] char,
    output logic [5:0] rowad,
    output logic [7:0] palabra,
    output logic [2:0] posicion,
    output logic       palabit
);

    localparam logic [9:0] X0_V = 10'(X0);
    localparam logic [9:0] Y0_V = 10'(Y0);

    logic [9:0] dx;
    logic [9:0] dy;
    logic       in_box;
    logic [7:0] rom_data;
    logic [2:0] rgb_next;

    assign dx = pixel_x - X0_V;
    assign dy = pixel_y - Y0_V;

    // Offsets are only meaningful once the coordinate is at or past the
    // corner; the high offset bits being zero then bounds the box size.
    assign in_box = (pixel_x >= X0_V) && (dx[9:5] == 5'd0) &&
                    (pixel_y >= Y0_V) && (dy[9:4] == 6'd0);

    assign char     = in_box ? dx[4:3] : 2'd0;
    assign posicion = in_box ? dx[2:0] : 3'd0;
    assign rowad    = in_box ? {dx[4:3], dy[3:0]} : 6'd0;

    caracter_font_rom u_font_rom (
        .addr (rowad),
        .data (rom_data)
    );

    assign palabra = in_box ? rom_data : 8'd0;
    assign palabit = in_box & palabra[3'd7 - posicion];

    always_comb begin
        rgb_next = 3'b000;
        if (video_on && palabit) begin
            rgb_next = {R, G, B};
        end
`ifdef CARACTER_BG_EN
        else if (video_on && in_box) begin
            rgb_next = ~{R, G, B};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            {r, g, b} <= 3'b000;
        end else begin
            {r, g, b} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_caracter.sv
module tb_caracter;

    localparam int X0 = 288;
    localparam int Y0 = 232;

    logic       clk = 1'b0;
    logic       rst;
    logic       video_on;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       R, G, B;
    logic       r, g, b;
    logic [1:0] char;
    logic [5:0] rowad;
    logic [7:0] palabra;
    logic [2:0] posicion;
    logic       palabit;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    caracter #(.X0(X0), .Y0(Y0)) dut (
        .clk      (clk),
        .rst      (rst),
        .video_on (video_on),
        .pixel_x  (pixel_x),
        .pixel_y  (pixel_y),
        .R        (R),
        .G        (G),
        .B        (B),
        .r        (r),
        .g        (g),
        .b        (b),
        .char     (char),
        .rowad    (rowad),
        .palabra  (palabra),
        .posicion (posicion),
        .palabit  (palabit)
    );

    // Glyph rows written from the letter shapes rather than a table.
    function automatic logic [7:0] glyph(input int c, input int row);
        if (row < 2 || row > 13) return 8'h00;
        case (c)
            0: return (row == 7 || row == 8) ? 8'hFE : 8'hC6;
            1: return (row == 2 || row == 13) ? 8'h7C : 8'hC6;
            2: return (row == 13) ? 8'hFE : 8'hC0;
            default: begin
                if (row == 2) return 8'h38;
                if (row == 3) return 8'h6C;
                if (row == 8) return 8'hFE;
                return 8'hC6;
            end
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pixel: drive on the falling edge, check the lookups, queue the
    // expected colour, then compare the registered colour after the edge.
    task automatic pix(input int x, input int y, input bit vo,
                       input logic [2:0] col, input bit rst_v);
        bit         inb;
        int         ddx, ddy;
        logic [7:0] m_word;
        logic       m_bit;
        logic [2:0] m_rgb;
        string      t;
        @(negedge clk);
        rst      = rst_v;
        video_on = vo;
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        {R, G, B} = col;
        #1;
        t   = $sformatf("(%0d,%0d)", x, y);
        inb = (x >= X0) && (x <= X0 + 31) && (y >= Y0) && (y <= Y0 + 15);
        ddx = x - X0;
        ddy = y - Y0;
        m_word = inb ? glyph(ddx / 8, ddy) : 8'h00;
        m_bit  = inb ? m_word[7 - (ddx % 8)] : 1'b0;
        chk({t, " char"},     32'(char),     inb ? 32'(ddx / 8) : 0);
        chk({t, " posicion"}, 32'(posicion), inb ? 32'(ddx % 8) : 0);
        chk({t, " rowad"},    32'(rowad),    inb ? 32'((ddx / 8) * 16 + ddy) : 0);
        chk({t, " palabra"},  32'(palabra),  32'(m_word));
        chk({t, " palabit"},  32'(palabit),  32'(m_bit));
        if (!rst_v) m_rgb = 3'b000;
        else if (vo && m_bit) m_rgb = col;
`ifdef CARACTER_BG_EN
        else if (vo && inb) m_rgb = ~col;
`endif
        else m_rgb = 3'b000;
        exp_q.push_back(m_rgb);
        tag_q.push_back({t, " rgb"});
        @(posedge clk);
        #1;
        chk(tag_q.pop_front(), 32'({r, g, b}), 32'(exp_q.pop_front()));
    endtask

    initial begin
        rst = 1'b0; video_on = 1'b0; pixel_x = '0; pixel_y = '0;
        {R, G, B} = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset rgb", 32'({r, g, b}), 0);

        // reset priority over a lit glyph pixel, then release
        pix(288, 236, 1, 3'b111, 0);
        pix(288, 236, 1, 3'b111, 0);
        pix(288, 236, 1, 3'b111, 1);
        chk("post-reset rgb", 32'({r, g, b}), 32'h7);

        // blank glyph row
        pix(302, 233, 1, 3'b110, 1);
        chk("blank rowad", 32'(rowad), 32'h11);
        chk("blank posicion", 32'(posicion), 6);

        // glyph pixel with mixed colour
        pix(288, 236, 1, 3'b101, 1);
        chk("glyph palabra", 32'(palabra), 32'hC6);
        chk("glyph rgb", 32'({r, g, b}), 32'h5);

        // column select inside O
        pix(297, 240, 1, 3'b011, 1);
        chk("col1 palabit", 32'(palabit), 1);
        pix(298, 240, 1, 3'b011, 1);
        chk("col2 palabit", 32'(palabit), 0);

        // blanking
        pix(288, 236, 0, 3'b101, 1);

        // reset in mid-stream blanks only that cycle
        pix(288, 236, 1, 3'b111, 0);
        pix(288, 236, 1, 3'b111, 1);

        // boundaries
        pix(319, 247, 1, 3'b111, 1);
        chk("corner rowad", 32'(rowad), 32'h3F);
        pix(287, 236, 1, 3'b111, 1);
        pix(320, 236, 1, 3'b111, 1);
        pix(288, 248, 1, 3'b111, 1);
        pix(288, 231, 1, 3'b111, 1);
        pix(319, 232, 1, 3'b111, 1);

        // row-4 sweep across all four glyphs and both side edges
        for (int x = 286; x <= 321; x++) begin
            pix(x, 236, 1, 3'(x % 7 + 1), 1);
        end

        // every row of the A glyph at its leftmost lit column region
        for (int y = Y0; y <= Y0 + 15; y++) begin
            pix(X0 + 26, y, 1, 3'b010, 1);
        end

        // scattered pixels around the box
        for (int i = 0; i < 40; i++) begin
            pix(int'($urandom_range(280, 330)), int'($urandom_range(226, 252)),
                bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/caracter.md
# caracter

Fixed four-glyph text overlay for the VGA pixel pipeline. It takes the current pixel coordinate from the sync generator and the foreground colour from the colour switches. It renders the word "HOLA" from an internal 8x16 font ROM and drives the 1-bit-per-channel colour outputs to the DAC. Internal lookup signals are exported as ports for debug.

## Interface
Parameters:
- X0, 288, left pixel column of the text box
- Y0, 232, top pixel row of the text box

Ports:
- clk  in  1  pixel clock; one clock domain; rising edge
- rst  in  1  reset; synchronous, active-low
- video_on  in  1  high while in the visible area
- pixel_x  in  10  current column
- pixel_y  in  10  current row
- R, G, B  in  1 each  foreground colour
- r, g, b  out  1 each  registered colour output
- char  out  2  glyph index within the box (0..3)
- rowad  out  6  font ROM address {char, glyph_row[3:0]}
- palabra  out  8  font row word; bit 7 is the leftmost pixel
- posicion  out  3  column within the glyph (0..7)
- palabit  out  1  selected font bit

## Operation
- Text box:
  - X0 <= pixel_x <= X0+31 and Y0 <= pixel_y <= Y0+15, inclusive.
  - in_box is the internal flag for this region.
- Derived values:
  - dx = pixel_x - X0, dy = pixel_y - Y0, using 10-bit unsigned arithmetic.
  - char = dx[4:3], posicion = dx[2:0], rowad = {char, dy[3:0]}.
  - palabra = font[rowad].
  - palabit = in_box & palabra[7 - posicion].
- Outside the box:
  - char, rowad, posicion and palabra are driven to 0.
  - palabit is 0.
- Glyphs (char 0..3 = H, O, L, A):
  - Rows 0, 1, 14 and 15 of every glyph are 8'h00.
  - H: rows 2-13 = C6, except rows 7-8 = FE.
  - O: rows 2 and 13 = 7C; rows 3-12 = C6.
  - L: rows 2-12 = C0; row 13 = FE.
  - A: row 2 = 38, row 3 = 6C, rows 4-7 = C6, row 8 = FE, rows 9-13 = C6.
- Colour:
  - Next r/g/b = {R,G,B} when video_on & palabit.
  - Otherwise next r/g/b = 0, subject to the Configuration section.
- Combinational/registered split:
  - char, rowad, palabra, posicion and palabit are purely combinational from pixel_x and pixel_y; rst has no effect on them.
  - r, g and b are the only state.

## Timing
- r/g/b latency: one clk cycle from pixel_x/pixel_y/video_on/R/G/B.
- rst low at a rising edge: r, g, b become 0 at that edge.
- Reset mid-frame blanks exactly the cycles during which rst is low.
- video_on low: r/g/b are 0 on the following cycle, regardless of palabit.
- No handshake: every clk cycle is one pixel.
- Box edges:
  - X0-1 and X0+32 (columns) and Y0-1 and Y0+16 (rows) lie outside the box.
  - No wrap-around: X0 and Y0 must satisfy X0+31 <= 1023 and Y0+15 <= 1023.

## Configuration
- CARACTER_BG_EN defined: inside the box, with video_on=1 and palabit=0, r/g/b = {~R,~G,~B}. This gives an inverse-colour background box.
- CARACTER_BG_EN undefined: those pixels output 0.
- Glyph pixels and pixels outside the box are identical in both builds.

## Structure
- Package caracter_pkg holds:
  - default X0/Y0;
  - GLYPH_W=8, GLYPH_H=16, N_CHARS=4;
  - the 64x8 font constant array.
- Sub-module caracter_font_rom: combinational 6-bit address to 8-bit data.
- The top level does the coordinate decode, bit select and colour register.

## Test plan
1. Reset priority: rst=0 for 2 cycles with video_on=1, R=G=B=1, pixel at (288,236) -> r=g=b=0 throughout; after rst=1, r=g=b=1 on the next edge.
2. Blank glyph row: (302,233) -> char=1, posicion=6, rowad=6'h11, palabra=8'h00, palabit=0; rgb=0 next cycle, plus the background case under CARACTER_BG_EN.
3. Glyph pixel: (288,236), R=1, G=0, B=1, video_on=1 -> char=0, rowad=6'h04, palabra=8'hC6, palabit=1; next cycle r=1, g=0, b=1.
4. Column select: (297,240) -> char=1, posicion=1, palabra=8'hC6, palabit=1. At (298,240) -> posicion=2, palabit=0.
5. Blanking: as case 3 but video_on=0 -> rgb=000 next cycle.
6. Boundaries:
   - (319,247) -> char=3, rowad=6'h3F, palabra=8'h00.
   - (287,236) and (320,236) -> all lookup outputs 0, palabit=0.
   - (288,248) -> all lookup outputs 0.
   - Sweep x from 286 to 321 at y=236 and check rgb against the H/O/L/A row-4 words C6, C6, C0, C6.
